// File: rtl/morse_symbol_fifo.sv
// Circular symbol FIFO between the morse encoder and the display/transmit stage.
// First-word fall-through read, edge-triggered pop, optional change-detect writes.
module morse_symbol_fifo #(
    parameter int WIDTH         = 20,
    parameter int DEPTH         = 10,
    parameter int CHANGE_DETECT = 1,
    parameter int OVERWRITE     = 0,
    parameter int CW            = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_w_data,
    input  logic             i_w_valid,
    input  logic             i_r_next,
    output logic [WIDTH-1:0] o_r_data,
    output logic             o_r_valid,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             buff_warn,
    output logic             o_overflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             have_last_q, have_last_d;
    logic             warn_q, warn_d;
    logic             ovf_q, ovf_d;
    logic             r_next_q;
    logic             wr_try, pop, store, full, empty;

    // DEPTH need not be a power of two, so wrap by explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        wr_try      = i_w_valid && ((CHANGE_DETECT == 0) || !have_last_q || (i_w_data != last_q));
        pop         = i_r_next && !r_next_q && !empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_d      = last_q;
        have_last_d = have_last_q;
        warn_d      = 1'b0;
        ovf_d       = ovf_q;
        store       = 1'b0;

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // The last attempted word is remembered even if it ends up dropped.
        if (wr_try) begin
            last_d      = i_w_data;
            have_last_d = 1'b1;
            if (!full || pop) begin
                store = 1'b1;
            end else begin
                warn_d = 1'b1;
                ovf_d  = 1'b1;
                if (OVERWRITE != 0) begin
                    store    = 1'b1;
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end
            end
        end
        if (store) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (pop && !store) begin
            count_d = count_q - 1'b1;
        end else if (store && !pop && !full) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
            warn_q      <= 1'b0;
            ovf_q       <= 1'b0;
            r_next_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
            warn_q      <= warn_d;
            ovf_q       <= ovf_d;
            r_next_q    <= i_r_next;
        end
    end

    // Storage is never reset; emptiness alone masks stale contents.
    always_ff @(posedge i_clk) begin
        if (store && !i_rst) begin
            mem_q[wr_ptr_q] <= i_w_data;
        end
    end

    assign o_r_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign o_r_valid  = !empty;
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_count    = count_q;
    assign buff_warn  = warn_q;
    assign o_overflow = ovf_q;
endmodule

// File: doc/morse_symbol_fifo.md
Name: morse_symbol_fifo

Overview:
- Parametrised single-clock circular FIFO between the morse symbol encoder (writer) and the display/transmit stage (reader).
- Successor to the fixed 20-bit, 10-entry symbol buffer. Adds:
  - configurable width and depth;
  - optional change-detect write qualification;
  - synchronous rising-edge read-advance;
  - drop-new or overwrite-oldest full policy;
  - occupancy and status outputs.

Parameters:
- WIDTH, 20, data word width in bits (>=1).
- DEPTH, 10, number of entries (>=2; need not be a power of two).
- CHANGE_DETECT, 1, 1 = a valid write is accepted only if i_w_data differs from the last attempted word; 0 = every valid write is accepted.
- OVERWRITE, 0, full policy: 0 = drop the incoming word; 1 = overwrite the oldest entry.
- CW, $clog2(DEPTH+1), width of o_count (derived, not overridden).

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_w_data  in  WIDTH  write data.
- i_w_valid  in  1  write request qualifier.
- i_r_next  in  1  read-advance level, synchronous to i_clk; its rising edge pops one entry.
- o_r_data  out  WIDTH  head entry, first-word fall-through; all zeros when empty.
- o_r_valid  out  1  high when not empty.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_count  out  CW  current occupancy, 0..DEPTH.
- buff_warn  out  1  one-cycle pulse whenever a word is dropped or overwritten.
- o_overflow  out  1  sticky flag; set on any buff_warn event, cleared only by i_rst.

Behaviour:
- Reset:
  - Reset is synchronous, active-high, and dominates all other inputs in the same cycle.
  - Clears: write/read pointers, count, buff_warn, o_overflow, the i_r_next edge register, the last-word register and its have_last flag.
  - Memory contents are not cleared; o_r_data reads 0 after reset because the FIFO is empty.
  - A reset mid-operation discards all contents; any write or pop presented in that cycle is ignored.
- Write attempt: wr_try = i_w_valid && (!CHANGE_DETECT || !have_last || i_w_data != last_word).
  - On wr_try, last_word <= i_w_data and have_last <= 1, whether or not the word is stored. A dropped word held constant is therefore not retried every cycle.
- Pop: pop = i_r_next && !r_next_q && !o_empty, where r_next_q is i_r_next delayed one clock.
  - A held-high i_r_next pops exactly once.
- Pointers: increment by 1 and wrap from DEPTH-1 to 0. Explicit compare, no power-of-two masking.
- Cases, evaluated per cycle:
  - wr_try, not full, no pop: store at wr_ptr, advance wr_ptr, count+1.
  - pop only: advance rd_ptr, count-1.
  - wr_try and pop, not full and not empty: both occur, count unchanged.
  - wr_try and pop when full: the pop frees a slot and the write is stored. count stays DEPTH, no buff_warn.
  - wr_try when empty with a pop edge: pop is ignored (empty), write stored, count = 1.
  - wr_try when full, no pop, OVERWRITE=0: word dropped, pointers and count unchanged, buff_warn = 1 for one cycle, o_overflow <= 1.
  - wr_try when full, no pop, OVERWRITE=1: word stored at wr_ptr (== rd_ptr), both pointers advance, count stays DEPTH, buff_warn = 1, o_overflow <= 1.
- Output timing:
  - buff_warn is registered: high in the cycle after the offending edge, low otherwise.
  - o_r_data, o_r_valid, o_full, o_empty and o_count are combinational from registered state.
  - A stored word is visible on o_r_data the cycle after the write edge if the FIFO was empty.

Test Plan:
- Reset, then 10 writes 1..10 with i_w_valid=1 (CHANGE_DETECT=1) -> o_count=10, o_full=1, o_r_data=1, buff_warn never high.
- Hold i_w_data=5 valid for 8 cycles after reset (CHANGE_DETECT=1) -> exactly one entry stored, o_count=1. Repeat with CHANGE_DETECT=0 -> o_count=8.
- Full with 1..10, write 11 (OVERWRITE=0) -> buff_warn pulses one cycle, o_overflow=1, o_r_data=1. With OVERWRITE=1 -> o_r_data=2 and the last pop returns 11.
- Hold i_r_next high 5 cycles on a FIFO holding 1..3 -> one pop, o_r_data=2, o_count=2. Three separate low-high toggles -> o_empty=1, o_r_data=0, the extra toggle is ignored.
- Wrap-around with DEPTH=4: write 1..4, pop 3, write 5..7 -> pop order 4,5,6,7, pointers wrap, o_count returns to 0.
- Full FIFO, same-cycle write 99 and pop edge -> no buff_warn, o_count stays 10. Then assert i_rst alongside a write -> o_count=0, o_overflow=0, write ignored.
